// File: rtl/control_unit_pipe.sv
// Decode/control stage of the pipeline. It turns the instruction class and
// opcode into registered EXE controls. A memory op keeps its controls
// registered for MEM_WAIT extra cycles and asks IF/ID to freeze meanwhile.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_RUN      | normal decode every edge (flush/hazard/invalid -> bubble)
//   ST_MEM_WAIT | memory op held, counter counting down, stall_out high
module control_unit_pipe #(
    parameter int CMD_W    = 4,
    parameter int MEM_WAIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [1:0]       mode,
    input  logic [3:0]       opcode,
    input  logic             s_in,
    input  logic             cond_pass,
    input  logic             hazard,
    input  logic             flush,
    output logic [CMD_W-1:0] exe_cmd,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             wb_en,
    output logic             b,
    output logic             s_out,
    output logic             valid_out,
    output logic             illegal,
    output logic             stall_out
);

    localparam int               CNT_W    = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               HAS_WAIT = (MEM_WAIT > 0);

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CMD_W-1:0] exe_cmd_d;
    logic             mem_r_en_d, mem_w_en_d, wb_en_d, b_d, s_out_d, valid_out_d, illegal_d;

    logic [3:0] dec_cmd;
    logic       dec_r, dec_w, dec_wb, dec_b, dec_s, dec_ok;

    // Pure instruction decode; dec_ok clears for reserved mode / undefined opcode.
    always_comb begin
        dec_cmd = 4'b0000;
        dec_r   = 1'b0;
        dec_w   = 1'b0;
        dec_wb  = 1'b0;
        dec_b   = 1'b0;
        dec_s   = 1'b0;
        dec_ok  = 1'b1;
        case (mode)
            2'b00: begin
                dec_wb = 1'b1;
                dec_s  = s_in;
                case (opcode)
                    4'b1101: dec_cmd = 4'b0001;
                    4'b1111: dec_cmd = 4'b1001;
                    4'b0100: dec_cmd = 4'b0010;
                    4'b0101: dec_cmd = 4'b0011;
                    4'b0010: dec_cmd = 4'b0100;
                    4'b0110: dec_cmd = 4'b0101;
                    4'b0000: dec_cmd = 4'b0110;
                    4'b1100: dec_cmd = 4'b0111;
                    4'b0001: dec_cmd = 4'b1000;
                    // Compare/test only update flags, never the register file.
                    4'b1010: begin
                        dec_cmd = 4'b0100;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b1;
                    end
                    4'b1000: begin
                        dec_cmd = 4'b0110;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b1;
                    end
                    default: begin
                        dec_ok = 1'b0;
                        dec_wb = 1'b0;
                        dec_s  = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                dec_cmd = 4'b0010;
                dec_r   = s_in;
                dec_w   = ~s_in;
                dec_wb  = s_in;
            end
            2'b10: begin
                dec_b = 1'b1;
            end
            default: begin
                dec_ok = 1'b0;
            end
        endcase
    end

    // Next state, wait counter and next registered controls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exe_cmd_d   = exe_cmd;
        mem_r_en_d  = mem_r_en;
        mem_w_en_d  = mem_w_en;
        wb_en_d     = wb_en;
        b_d         = b;
        s_out_d     = s_out;
        valid_out_d = valid_out;
        illegal_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                exe_cmd_d   = '0;
                mem_r_en_d  = 1'b0;
                mem_w_en_d  = 1'b0;
                wb_en_d     = 1'b0;
                b_d         = 1'b0;
                s_out_d     = 1'b0;
                valid_out_d = 1'b0;
                cnt_d       = '0;
                if (flush || hazard || !valid_in || !cond_pass) begin
                    illegal_d = 1'b0;
                end else if (!dec_ok) begin
                    illegal_d = 1'b1;
                end else begin
                    exe_cmd_d   = CMD_W'(dec_cmd);
                    mem_r_en_d  = dec_r;
                    mem_w_en_d  = dec_w;
                    wb_en_d     = dec_wb;
                    b_d         = dec_b;
                    s_out_d     = dec_s;
                    valid_out_d = 1'b1;
                    if (HAS_WAIT && (dec_r || dec_w)) begin
                        state_d = ST_MEM_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (flush) begin
                    exe_cmd_d   = '0;
                    mem_r_en_d  = 1'b0;
                    mem_w_en_d  = 1'b0;
                    wb_en_d     = 1'b0;
                    b_d         = 1'b0;
                    s_out_d     = 1'b0;
                    valid_out_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_RUN;
                end else if (cnt_q <= CNT_ONE) begin
                    // Last held edge; guard against a zero count so it never wraps.
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and output registers; reset forces a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            exe_cmd   <= '0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            wb_en     <= 1'b0;
            b         <= 1'b0;
            s_out     <= 1'b0;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exe_cmd   <= exe_cmd_d;
            mem_r_en  <= mem_r_en_d;
            mem_w_en  <= mem_w_en_d;
            wb_en     <= wb_en_d;
            b         <= b_d;
            s_out     <= s_out_d;
            valid_out <= valid_out_d;
            illegal   <= illegal_d;
        end
    end

    // Freeze request follows the FSM directly, so it drops as soon as reset hits.
    always_comb begin
        stall_out = (state_q == ST_MEM_WAIT);
    end

endmodule

// File: tb/tb_control_unit_pipe.sv
// Bench for control_unit_pipe: two instances (MEM_WAIT=2 and MEM_WAIT=0)
// share one stimulus stream and are compared every cycle against a
// behavioural model, plus directed scenarios with literal expectations.
module tb_control_unit_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_in = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] opcode = 4'b0000;
    logic       s_in = 1'b0;
    logic       cond_pass = 1'b0;
    logic       hazard = 1'b0;
    logic       flush = 1'b0;

    logic [3:0] a_cmd, z_cmd;
    logic a_r, a_w, a_wb, a_b, a_s, a_v, a_ill, a_stall;
    logic z_r, z_w, z_wb, z_b, z_s, z_v, z_ill, z_stall;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    control_unit_pipe #(.CMD_W(4), .MEM_WAIT(2)) u_w2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mode(mode), .opcode(opcode),
        .s_in(s_in), .cond_pass(cond_pass), .hazard(hazard), .flush(flush),
        .exe_cmd(a_cmd), .mem_r_en(a_r), .mem_w_en(a_w), .wb_en(a_wb), .b(a_b),
        .s_out(a_s), .valid_out(a_v), .illegal(a_ill), .stall_out(a_stall)
    );

    control_unit_pipe #(.CMD_W(4), .MEM_WAIT(0)) u_w0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mode(mode), .opcode(opcode),
        .s_in(s_in), .cond_pass(cond_pass), .hazard(hazard), .flush(flush),
        .exe_cmd(z_cmd), .mem_r_en(z_r), .mem_w_en(z_w), .wb_en(z_wb), .b(z_b),
        .s_out(z_s), .valid_out(z_v), .illegal(z_ill), .stall_out(z_stall)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0] cmd;
        logic r, w, wb, br, s, v, ill;
    } outs_t;

    localparam outs_t BUBBLE = '0;
    int    waits [2] = '{2, 0};
    outs_t exp_o [2] = '{BUBBLE, BUBBLE};
    int    rem   [2] = '{0, 0};   // remaining held edges after the registering edge

    function automatic outs_t ref_decode(input logic [1:0] md, input logic [3:0] op,
                                         input logic s, output bit ok);
        outs_t o;
        o  = BUBBLE;
        ok = 1'b1;
        if (md == 2'b00) begin
            o.wb = 1'b1;
            o.s  = s;
            case (op)
                4'hD: o.cmd = 4'd1;
                4'hF: o.cmd = 4'd9;
                4'h4: o.cmd = 4'd2;
                4'h5: o.cmd = 4'd3;
                4'h2: o.cmd = 4'd4;
                4'h6: o.cmd = 4'd5;
                4'h0: o.cmd = 4'd6;
                4'hC: o.cmd = 4'd7;
                4'h1: o.cmd = 4'd8;
                4'hA: begin o.cmd = 4'd4; o.wb = 1'b0; o.s = 1'b1; end
                4'h8: begin o.cmd = 4'd6; o.wb = 1'b0; o.s = 1'b1; end
                default: ok = 1'b0;
            endcase
        end else if (md == 2'b01) begin
            o.cmd = 4'd2;
            o.r   = s;
            o.w   = !s;
            o.wb  = s;
        end else if (md == 2'b10) begin
            o.br = 1'b1;
        end else begin
            ok = 1'b0;
        end
        if (!ok) o = BUBBLE;
        o.v = ok;
        return o;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                exp_o[i] = BUBBLE;
                rem[i]   = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                outs_t d;
                bit    ok;
                if (flush) begin
                    exp_o[i] = BUBBLE;
                    rem[i]   = 0;
                end else if (rem[i] > 0) begin
                    rem[i]       = rem[i] - 1;
                    exp_o[i].ill = 1'b0;
                end else if (hazard || !valid_in || !cond_pass) begin
                    exp_o[i] = BUBBLE;
                end else begin
                    d = ref_decode(mode, opcode, s_in, ok);
                    if (!ok) begin
                        exp_o[i]     = BUBBLE;
                        exp_o[i].ill = 1'b1;
                    end else begin
                        exp_o[i] = d;
                        if (d.r || d.w) rem[i] = waits[i];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [11:0] act, exp;
                act = (i == 0) ? {a_cmd, a_r, a_w, a_wb, a_b, a_s, a_v, a_ill, a_stall}
                               : {z_cmd, z_r, z_w, z_wb, z_b, z_s, z_v, z_ill, z_stall};
                exp = {exp_o[i], (rem[i] > 0)};
                vectors++;
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL cycle_cmp inst=%0d t=%0t got=%h expected=%h", i, $time, act, exp);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] md, input logic [3:0] op,
                         input bit s, input bit cp, input bit hz, input bit fl);
        valid_in  = v;
        mode      = md;
        opcode    = op;
        s_in      = s;
        cond_pass = cp;
        hazard    = hz;
        flush     = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1;
        chk_en = 1'b1;
        chk("reset_cmd", 32'(a_cmd), 32'h0);
        chk("reset_valid", 32'(a_v), 32'h0);
        chk("reset_stall", 32'(a_stall), 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;

        // ADD with S
        drive(1, 2'b00, 4'b0100, 1, 1, 0, 0);
        cyc();
        chk("add_cmd", 32'(a_cmd), 32'h2);
        chk("add_wb_s_v", {29'd0, a_wb, a_s, a_v}, 32'h7);
        chk("add_stall", 32'(a_stall), 32'h0);

        // LDR, MEM_WAIT=2: held 3 cycles, stall 2 cycles
        drive(1, 2'b01, 4'b0000, 1, 1, 0, 0);
        cyc();
        chk("ldr_c1", {a_r, a_wb, a_stall}, 3'b111);
        chk("ldr_w0_stall", {z_r, z_stall}, 2'b10);
        drive(1, 2'b00, 4'b0100, 0, 1, 1, 0);   // hazard ignored during wait
        cyc();
        chk("ldr_c2", {a_r, a_wb, a_stall}, 3'b111);
        drive(1, 2'b00, 4'b0100, 0, 1, 0, 0);
        cyc();
        chk("ldr_c3", {a_r, a_wb, a_stall}, 3'b110);
        cyc();
        chk("ldr_next_cmd", {a_cmd, a_r, a_v}, 6'b0010_01);

        // STR then flush
        drive(1, 2'b01, 4'b0000, 0, 1, 0, 0);
        cyc();
        chk("str_c1", {a_w, a_wb, a_stall}, 3'b101);
        drive(1, 2'b01, 4'b0000, 0, 1, 0, 1);
        cyc();
        chk("str_flush", {a_w, a_v, a_stall}, 3'b000);
        drive(0, 2'b00, 4'b0000, 0, 1, 0, 0);
        cyc();

        // CMP s_in=0, then hazard
        drive(1, 2'b00, 4'b1010, 0, 1, 0, 0);
        cyc();
        chk("cmp", {a_cmd, a_wb, a_s, a_v}, 7'b0100_011);
        drive(1, 2'b00, 4'b1010, 0, 1, 1, 0);
        cyc();
        chk("cmp_hazard", {a_cmd, a_v}, 5'b0000_0);

        // reserved mode and undefined opcode
        drive(1, 2'b11, 4'b0000, 0, 1, 0, 0);
        cyc();
        chk("mode11_ill", {a_ill, a_v, a_cmd}, 6'b10_0000);
        drive(0, 2'b00, 4'b0000, 0, 1, 0, 0);
        cyc();
        chk("mode11_pulse", 32'(a_ill), 32'h0);
        drive(1, 2'b00, 4'b0011, 1, 1, 0, 0);
        cyc();
        chk("undef_ill", {a_ill, a_v, a_wb, a_s}, 4'b1000);
        drive(0, 2'b00, 4'b0000, 0, 1, 0, 0);
        cyc();
        chk("undef_pulse", 32'(a_ill), 32'h0);

        // async reset mid-wait
        drive(1, 2'b01, 4'b0000, 1, 1, 0, 0);
        cyc();
        chk("pre_rst_stall", 32'(a_stall), 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("rst_async", {a_stall, a_r, a_wb, a_v}, 4'b0000);
        chk("rst_w0_stall", 32'(z_stall), 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        drive(1, 2'b00, 4'b0100, 0, 1, 0, 0);
        cyc();
        chk("post_rst_add", {a_cmd, a_v, a_stall}, 6'b0010_10);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 85, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 7);
            cyc();
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
